// File: rtl/vram_arbiter.sv
// VRAM port arbiter: video fetch priority, posted CPU writes, CPU reads.
// Owns the single 16K x 12 VRAM port.
module vram_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 12,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              wr_pending,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WFIFO_DEPTH);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [0:0]       state;

  logic fifo_empty;
  logic wr_accept;
  logic rd_issue;
  logic deq;

  assign vid_data   = mem_q;
  assign fifo_empty = (count == '0);
  assign deq        = !vid_active && !fifo_empty;

  // cpu_ack high means this request was already consumed
  assign wr_accept = cpu_req && cpu_we && !cpu_ack
                  && (state == IDLE) && (count < FULL);

  assign rd_issue = cpu_req && !cpu_we && !cpu_ack
                 && fifo_empty && !vid_active
                 && (state == IDLE);

  always_comb begin
    count_next = count;
    case ({wr_accept, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    mem_addr  = vid_addr;
    mem_we    = 1'b0;
    mem_wdata = fifo_data[rd_ptr];
    if (deq) begin
      mem_addr = fifo_addr[rd_ptr];
      mem_we   = !rst;
    end else if (rd_issue) begin
      mem_addr = cpu_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_pending <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      state      <= IDLE;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      wr_pending <= (count_next != '0);
      cpu_ack    <= wr_accept || (state == RD_DATA);
      // RAM latency is fixed, so capture regardless of vid_active
      case (state)
        IDLE: begin
          if (rd_issue)
            state <= RD_DATA;
        end
        RD_DATA: begin
          cpu_rdata <= mem_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
